// File: rtl/cic3_row_readout.sv
// Filter-row capture into a 2-entry frame FIFO, serialised as {tag, data[, parity]} LSB first.
// Optional even-parity trailer bit is enabled by defining CIC3_ROW_PARITY_EN.
module cic3_row_readout #(
    parameter int NUM_FILTERS = 24,
    parameter int TAG_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_FILTERS-1:0] filt_in,
    input  logic                   sample,
    input  logic                   clr_ovf,
    input  logic                   ser_ready,
    output logic                   ser_data,
    output logic                   ser_valid,
    output logic                   ser_sof,
    output logic                   overflow
);
    localparam int ENTRY_W = TAG_W + NUM_FILTERS;
    localparam int MAX_SEG = (NUM_FILTERS > TAG_W) ? NUM_FILTERS : TAG_W;
    localparam int CNT_W   = ($clog2(MAX_SEG) < 1) ? 1 : $clog2(MAX_SEG);

`ifdef CIC3_ROW_PARITY_EN
    localparam int SHR_W = ENTRY_W + 1;
    typedef enum logic [1:0] {IDLE, HDR, DATA, PAR} state_t;
`else
    localparam int SHR_W = ENTRY_W;
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    logic [ENTRY_W-1:0] mem [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count;
    logic [TAG_W-1:0]   tag_cnt;
    logic [SHR_W-1:0]   shreg;
    logic [CNT_W-1:0]   bit_cnt;
    state_t             state, state_next;
    logic               xfer, last_bit, pop, push, drop, load;
    logic [ENTRY_W-1:0] load_entry;

    // Reorder an entry {tag, data} into transmit order: tag first, then data, then parity.
    function automatic logic [SHR_W-1:0] frame_of(input logic [ENTRY_W-1:0] entry);
`ifdef CIC3_ROW_PARITY_EN
        return {^entry, entry[NUM_FILTERS-1:0], entry[ENTRY_W-1 -: TAG_W]};
`else
        return {entry[NUM_FILTERS-1:0], entry[ENTRY_W-1 -: TAG_W]};
`endif
    endfunction

    assign ser_valid = (state != IDLE);
    assign ser_data  = ser_valid & shreg[0];
    assign ser_sof   = (state == HDR) && (bit_cnt == '0);
    assign xfer      = ser_valid & ser_ready;
`ifdef CIC3_ROW_PARITY_EN
    assign last_bit  = (state == PAR);
`else
    assign last_bit  = (state == DATA) && (bit_cnt == CNT_W'(NUM_FILTERS - 1));
`endif
    // The head entry stays in the FIFO until its last bit leaves, so a full FIFO
    // can still accept a sample on the cycle that frees a slot.
    assign pop  = xfer & last_bit;
    assign push = sample & ((count != 2'd2) | pop);
    assign drop = sample & (count == 2'd2) & ~pop;
    assign load_entry = (state == IDLE) ? mem[rd_ptr] : mem[~rd_ptr];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    state_next = HDR;
                    load       = 1'b1;
                end
            end
            HDR: begin
                if (xfer && bit_cnt == CNT_W'(TAG_W - 1)) state_next = DATA;
            end
            DATA: begin
                if (xfer && bit_cnt == CNT_W'(NUM_FILTERS - 1)) begin
`ifdef CIC3_ROW_PARITY_EN
                    state_next = PAR;
`else
                    state_next = (count == 2'd2) ? HDR : IDLE;
                    load       = (count == 2'd2);
`endif
                end
            end
`ifdef CIC3_ROW_PARITY_EN
            PAR: begin
                if (xfer) begin
                    state_next = (count == 2'd2) ? HDR : IDLE;
                    load       = (count == 2'd2);
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            tag_cnt  <= '0;
            overflow <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= state_next;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr  <= ~wr_ptr;
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (drop) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (load) shreg <= frame_of(load_entry);
            else if (xfer) shreg <= shreg >> 1;
            if (load || (xfer && state_next != state)) bit_cnt <= '0;
            else if (xfer) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Storage only; occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= {tag_cnt, filt_in};
    end

endmodule

// File: tb/tb_cic3_row_readout.sv
// Directed + randomized bench for cic3_row_readout against a frame-queue reference model.
// Set CIC3_ROW_PARITY_EN to exercise the parity trailer.
module tb_cic3_row_readout;
    localparam int NF = 24;
    localparam int TW = 4;
`ifdef CIC3_ROW_PARITY_EN
    localparam int FLEN = TW + NF + 1;
`else
    localparam int FLEN = TW + NF;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] filt_in = '0;
    logic          sample = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          ser_ready = 1'b0;
    logic          ser_data, ser_valid, ser_sof, overflow;

    cic3_row_readout #(.NUM_FILTERS(NF), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .filt_in(filt_in), .sample(sample),
        .clr_ovf(clr_ovf), .ser_ready(ser_ready), .ser_data(ser_data),
        .ser_valid(ser_valid), .ser_sof(ser_sof), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: queued frames {tag, data}, bit position, sticky flag.
    logic [TW+NF-1:0] exp_q[$];
    logic [TW-1:0]    tag_log[$];
    logic [TW-1:0]    tag_m = '0;
    int               bit_idx = 0;
    logic             ovf_exp = 1'b0;
    logic             hold_pend = 1'b0;
    logic             prev_data, prev_sof;
    int               n_assert = 0;
    int               n_fail = 0;

    function automatic logic frame_bit(input logic [TW+NF-1:0] e, input int idx);
        logic [TW-1:0] t;
        logic [NF-1:0] f;
        t = e[TW+NF-1:NF];
        f = e[NF-1:0];
        if (idx < TW) return t[idx];
        else if (idx < TW + NF) return f[idx-TW];
        else return ^e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check and advance the model at negedge, then return just after posedge.
    task automatic tick();
        logic dropped;
        dropped = 1'b0;
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            tag_m = '0;
            bit_idx = 0;
            ovf_exp = 1'b0;
            hold_pend = 1'b0;
        end else begin
            chk("overflow", {31'b0, overflow}, {31'b0, ovf_exp});
            if (hold_pend) begin
                chk("hold_data", {31'b0, ser_data}, {31'b0, prev_data});
                chk("hold_sof", {31'b0, ser_sof}, {31'b0, prev_sof});
            end
            if (exp_q.size() == 0) begin
                chk("idle_valid", {31'b0, ser_valid}, 32'd0);
            end else if (ser_valid && ser_ready) begin
                chk("bit", {31'b0, ser_data}, {31'b0, frame_bit(exp_q[0], bit_idx)});
                chk("sof", {31'b0, ser_sof}, {31'b0, (bit_idx == 0)});
                bit_idx++;
                if (bit_idx == FLEN) begin
                    tag_log.push_back(exp_q[0][TW+NF-1:NF]);
                    void'(exp_q.pop_front());
                    bit_idx = 0;
                end
            end
            hold_pend = ser_valid && !ser_ready;
            prev_data = ser_data;
            prev_sof = ser_sof;
            if (sample) begin
                if (exp_q.size() < 2) begin
                    exp_q.push_back({tag_m, filt_in});
                    tag_m = tag_m + 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
            ovf_exp = dropped ? 1'b1 : (clr_ovf ? 1'b0 : ovf_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tag_log.delete();
    endtask

    task automatic pulse_sample(input logic [NF-1:0] d);
        filt_in = d;
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int start;
        int c;
        start = tag_log.size();
        c = 0;
        while (tag_log.size() < start + n && c < budget) begin
            tick();
            c++;
        end
        chk("frame_timeout", {31'b0, (tag_log.size() >= start + n)}, 32'd1);
    endtask

    initial begin
        int c;
        // Reset state
        tick();
        tick();
        chk("rst_valid", {31'b0, ser_valid}, 32'd0);
        chk("rst_sof", {31'b0, ser_sof}, 32'd0);
        chk("rst_data", {31'b0, ser_data}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b0;

        // Single frame and latency
        ser_ready = 1'b1;
        pulse_sample(24'hA50F3C);
        chk("lat_n1_valid", {31'b0, ser_valid}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'b0, ser_valid}, 32'd1);
        chk("lat_n2_sof", {31'b0, ser_sof}, 32'd1);
        wait_frames(1, 60);
        chk("single_after_valid", {31'b0, ser_valid}, 32'd0);
        chk("single_tag", {28'b0, tag_log[0]}, 32'd0);

        // Backpressure: ready toggles every cycle
        do_reset();
        pulse_sample(24'hA50F3C);
        c = 0;
        while (tag_log.size() < 1 && c < 200) begin
            ser_ready = ~ser_ready;
            tick();
            c++;
        end
        chk("bp_done", {31'b0, (tag_log.size() == 1)}, 32'd1);

        // Overflow: three samples with the output stalled
        do_reset();
        ser_ready = 1'b0;
        pulse_sample(NF'($urandom));
        pulse_sample(NF'($urandom));
        pulse_sample(NF'($urandom));
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        tick();
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", {31'b0, overflow}, 32'd0);
        ser_ready = 1'b1;
        wait_frames(2, 120);
        pulse_sample(NF'($urandom));
        wait_frames(1, 60);
        chk("ovf_tags", {20'b0, tag_log[0], tag_log[1], tag_log[2]}, 32'h012);

        // Sample coincides with the last-bit transfer while full
        do_reset();
        ser_ready = 1'b0;
        pulse_sample(NF'($urandom));
        pulse_sample(NF'($urandom));
        ser_ready = 1'b1;
        c = 0;
        while (!(bit_idx == FLEN - 1 && ser_valid) && c < 100) begin
            tick();
            c++;
        end
        chk("simul_reach", {31'b0, (bit_idx == FLEN - 1)}, 32'd1);
        pulse_sample(NF'($urandom));
        chk("simul_ovf", {31'b0, overflow}, 32'd0);
        chk("simul_nogap_valid", {31'b0, ser_valid}, 32'd1);
        chk("simul_nogap_sof", {31'b0, ser_sof}, 32'd1);
        wait_frames(2, 150);
        chk("simul_tags", {20'b0, tag_log[0], tag_log[1], tag_log[2]}, 32'h012);

        // Tag wrap over 17 frames
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pulse_sample(NF'($urandom));
            wait_frames(1, 60);
        end
        for (int i = 0; i < 17; i++) chk("wrap_tag", {28'b0, tag_log[i]}, i % 16);

        // Reset during the 10th data bit
        do_reset();
        pulse_sample(NF'($urandom));
        c = 0;
        while (!(bit_idx == TW + 9 && ser_valid) && c < 60) begin
            tick();
            c++;
        end
        chk("midrst_reach", {31'b0, (bit_idx == TW + 9)}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_valid", {31'b0, ser_valid}, 32'd0);
        chk("midrst_data", {31'b0, ser_data}, 32'd0);
        reset = 1'b0;
        tick();
        chk("midrst_quiet", {31'b0, ser_valid}, 32'd0);
        tag_log.delete();
        pulse_sample(NF'($urandom));
        wait_frames(1, 60);
        chk("midrst_tag", {28'b0, tag_log[0]}, 32'd0);

        // Randomized traffic, backpressure and clears
        do_reset();
        for (int i = 0; i < 600; i++) begin
            filt_in = NF'($urandom);
            sample = ($urandom_range(0, 15) == 0);
            ser_ready = $urandom_range(0, 3) != 0;
            clr_ovf = ($urandom_range(0, 31) == 0);
            tick();
        end
        sample = 1'b0;
        clr_ovf = 1'b0;
        ser_ready = 1'b1;
        for (int i = 0; i < 80; i++) tick();
        chk("rand_drained", {31'b0, ser_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
